// File: rtl/mix_columns_if.sv
// Handshake bundle for the MixColumns engine: input state channel, result channel and busy flag.
// The producer/consumer side uses the master modport and the engine uses the slave modport.
interface mix_columns_if #(
    parameter int NCOL = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [32*NCOL-1:0]   in_state;
    logic                 in_inv;
    logic                 out_valid;
    logic                 out_ready;
    logic [32*NCOL-1:0]   out_state;
    logic                 busy;

    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns / InvMixColumns over an NCOL-column state, COLS_PER_CYC columns per clock.
// Column k occupies bits [32*NCOL-1-32k -: 32]; byte a is the MSB of each column.
//
// state | meaning
// IDLE  | waiting for a state, in_ready high
// RUN   | transforming COLS_PER_CYC columns per cycle into the result register
// DONE  | result held on out_state until out_ready
module mix_columns_engine #(
    parameter int NCOL         = 4,
    parameter int COLS_PER_CYC = 1
) (
    input logic         clk,
    input logic         rst,
    mix_columns_if.slave bus
);
    localparam int N  = NCOL / COLS_PER_CYC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((NCOL % COLS_PER_CYC) != 0 ||
            !(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4 || COLS_PER_CYC == NCOL)) begin : g_bad_cfg
            $error("mix_columns_engine: illegal COLS_PER_CYC for this NCOL");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [32*NCOL-1:0]   src_q, src_d;
    logic [32*NCOL-1:0]   res_q, res_d;
    logic                 inv_q, inv_d;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 2/4/8 of every byte let both directions share one xtime chain per byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] b  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            b[i]  = c[31-8*i -: 8];
            x2[i] = xtime(b[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (inv) begin
                r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                               ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ b[(i+1)%4])
                               ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ b[(i+2)%4])
                               ^ (x8[(i+3)%4] ^ b[(i+3)%4]);
            end else begin
                r[31-8*i -: 8] = x2[i]
                               ^ (x2[(i+1)%4] ^ b[(i+1)%4])
                               ^ b[(i+2)%4]
                               ^ b[(i+3)%4];
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            res_q   <= res_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        res_d   = res_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    src_d   = bus.in_state;
                    inv_d   = bus.in_inv;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int j = 0; j < COLS_PER_CYC; j++) begin
                    res_d[32*(NCOL-1-(int'(cnt_q)*COLS_PER_CYC+j)) +: 32] =
                        mix_col(src_q[32*(NCOL-1-(int'(cnt_q)*COLS_PER_CYC+j)) +: 32], inv_q);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N-1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_state = res_q;
endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine at COLS_PER_CYC = 1, 2 and 4 with a result scoreboard
// and an independent shift-and-add GF(2^8) reference model.
module tb_mix_columns_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    int           cyc = 0;
    int           sel;
    logic         t_in_valid, t_in_inv, t_out_ready;
    logic [127:0] t_in_state;
    logic         o_in_ready, o_out_valid, o_busy;
    logic [127:0] o_out_state;

    int checks = 0;
    int errors = 0;
    int t_acc  = 0;
    logic [127:0] sb_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    mix_columns_if #(.NCOL(4)) if1 ();
    mix_columns_if #(.NCOL(4)) if2 ();
    mix_columns_if #(.NCOL(4)) if4 ();

    assign if1.in_valid  = t_in_valid && (sel == 1);
    assign if2.in_valid  = t_in_valid && (sel == 2);
    assign if4.in_valid  = t_in_valid && (sel == 4);
    assign if1.out_ready = t_out_ready && (sel == 1);
    assign if2.out_ready = t_out_ready && (sel == 2);
    assign if4.out_ready = t_out_ready && (sel == 4);
    assign if1.in_state  = t_in_state;
    assign if2.in_state  = t_in_state;
    assign if4.in_state  = t_in_state;
    assign if1.in_inv    = t_in_inv;
    assign if2.in_inv    = t_in_inv;
    assign if4.in_inv    = t_in_inv;

    always_comb begin
        o_in_ready  = if1.in_ready;
        o_out_valid = if1.out_valid;
        o_busy      = if1.busy;
        o_out_state = if1.out_state;
        if (sel == 2) begin
            o_in_ready  = if2.in_ready;
            o_out_valid = if2.out_valid;
            o_busy      = if2.busy;
            o_out_state = if2.out_state;
        end else if (sel == 4) begin
            o_in_ready  = if4.in_ready;
            o_out_valid = if4.out_valid;
            o_busy      = if4.busy;
            o_out_state = if4.out_state;
        end
    end

    mix_columns_engine #(.NCOL(4), .COLS_PER_CYC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    mix_columns_engine #(.NCOL(4), .COLS_PER_CYC(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    mix_columns_engine #(.NCOL(4), .COLS_PER_CYC(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] r;
        r = '0;
        if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(cf[(j - i + 4) % 4], s[127-32*k-8*j -: 8]);
                end
                r[127-32*k-8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] exp);
        int k;
        @(negedge clk);
        t_in_state = s;
        t_in_inv   = inv;
        t_in_valid = 1'b1;
        k = 0;
        while (!o_in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", o_in_ready, 1'b1);
        t_acc = cyc;
        sb_q.push_back(exp);
        @(negedge clk);
        t_in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int n);
        int k;
        k = 0;
        while (!o_out_valid && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk("out_valid_seen", o_out_valid, 1'b1);
        chk("latency", cyc - t_acc, n + 1);
    endtask

    task automatic recv(input int n);
        logic [127:0] exp;
        wait_valid(n);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        chk("out_state", o_out_state, exp);
        t_out_ready = 1'b1;
        @(negedge clk);
        t_out_ready = 1'b0;
        chk("handoff_valid", o_out_valid, 1'b0);
        chk("handoff_ready", o_in_ready, 1'b1);
        chk("handoff_hold", o_out_state, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] v1, e1, v2, exp_bp, r;
        logic         ri;
        sel         = 1;
        rst         = 1'b1;
        t_in_valid  = 1'b0;
        t_in_inv    = 1'b0;
        t_out_ready = 1'b0;
        t_in_state  = '0;
        v1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        e1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_out_valid", o_out_valid, 1'b0);
        chk("rst_in_ready", o_in_ready, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_out_state", o_out_state, '0);

        // known forward vector, then inverse round-trip
        send(v1, 1'b0, e1);
        chk("run_busy", o_busy, 1'b1);
        chk("run_in_ready", o_in_ready, 1'b0);
        recv(4);
        send(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1,
             128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
        recv(4);

        for (int i = 0; i < 4; i++) begin
            r  = {$urandom, $urandom, $urandom, $urandom};
            ri = 1'($urandom_range(0, 1));
            send(r, ri, model(r, ri));
            recv(4);
        end

        // backpressure: a different state waits on in_valid while DONE stalls
        v2 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        send(v1, 1'b0, e1);
        wait_valid(4);
        exp_bp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        t_in_state = v2;
        t_in_inv   = 1'b0;
        t_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_state", o_out_state, exp_bp);
            chk("bp_in_ready", o_in_ready, 1'b0);
            chk("bp_busy", o_busy, 1'b1);
            chk("bp_valid", o_out_valid, 1'b1);
            @(negedge clk);
        end
        t_out_ready = 1'b1;
        @(negedge clk);
        t_out_ready = 1'b0;
        chk("bp_in_ready_after", o_in_ready, 1'b1);
        chk("bp_valid_after", o_out_valid, 1'b0);
        t_acc = cyc;
        sb_q.push_back(model(v2, 1'b0));
        @(negedge clk);
        t_in_valid = 1'b0;
        chk("bp_accepted_busy", o_busy, 1'b1);
        recv(4);

        // reset during the second RUN cycle
        send(v2, 1'b1, model(v2, 1'b1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        chk("mrst_out_valid", o_out_valid, 1'b0);
        chk("mrst_out_state", o_out_state, '0);
        chk("mrst_busy", o_busy, 1'b0);
        chk("mrst_in_ready", o_in_ready, 1'b1);
        send(v1, 1'b0, e1);
        recv(4);

        // mode isolation: inputs change while RUN is in progress
        send(v2, 1'b0, model(v2, 1'b0));
        for (int i = 0; i < 3; i++) begin
            t_in_inv   = ~t_in_inv;
            t_in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        recv(4);

        // parallelism sweep
        sel = 2;
        @(negedge clk);
        send(v1, 1'b0, e1);
        recv(2);
        send(v2, 1'b1, model(v2, 1'b1));
        recv(2);
        sel = 4;
        @(negedge clk);
        send(v1, 1'b0, e1);
        recv(1);
        send(v2, 1'b1, model(v2, 1'b1));
        recv(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Parametrised, sequential successor to the 32-bit MixColumns datapath.
- Applies AES MixColumns (encrypt) or InvMixColumns (decrypt) to a full multi-column state, processing COLS_PER_CYC columns per clock.
- Uses valid/ready handshakes on input and output.
- Sits between ShiftRows and AddRoundKey in the round pipeline of the CRC-protected crypto datapath.

Parameters:
- NCOL, 4: number of 32-bit columns in the state (4 = AES-128 state).
- COLS_PER_CYC, 1: columns transformed per RUN cycle. Legal values are 1, 2, 4 and NCOL. NCOL % COLS_PER_CYC != 0 is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_state/in_inv are valid.
- in_ready  out  1  engine can accept a state.
- in_state  in  32*NCOL  input state. Column k = bits [32*NCOL-1-32k -: 32]. Byte a is the MSB of each column.
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns. Sampled at accept.
- out_valid  out  1  out_state holds a completed result.
- out_ready  in  1  consumer takes the result.
- out_state  out  32*NCOL  transformed state, same column/byte ordering as in_state.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, column counter 0, out_state=0, out_valid=0, busy=0, in_ready=1 from the following cycle.
  - Reset overrides everything, including mid-RUN and DONE. Any partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_state and in_inv, clear counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle transforms columns [cnt*COLS_PER_CYC, cnt*COLS_PER_CYC+COLS_PER_CYC-1] of the latched state into the result register. Untouched columns keep their prior value.
  - cnt increments each cycle. After N=NCOL/COLS_PER_CYC cycles, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_state is stable while out_ready=0; stalls indefinitely.
  - On out_ready=1: go to IDLE, out_valid=0 next cycle. out_state keeps its last value.
  - No same-cycle accept. A new input is accepted no earlier than the cycle after the handoff.
- Latency: accept at edge ending cycle T; out_valid=1 in cycle T+N+1. Minimum initiation interval is N+2 cycles.
- in_state/in_inv changes after accept have no effect on the operation in flight.
- Column arithmetic is GF(2^8) with polynomial 0x11B. xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0).
  - Forward, per output byte (rows rotate a,b,c,d):
    - r0 = 2a^3b^c^d
    - r1 = 2b^3c^d^a
    - r2 = 2c^3d^a^b
    - r3 = 2d^3a^b^c
  - Inverse: same rotation with coefficients 0e,0b,0d,09 replacing 02,03,01,01.
  - Both paths are pure XOR/xtime trees: no lookup tables, no multipliers.
- Mode is per-state. All columns of one state use the in_inv latched at accept.
- busy = (state != IDLE).

Test Plan:
- Known vector, NCOL=4, CPC=1, in_inv=0:
  - Stimulus: in_state=128'hdb135345_f20a225c_01010101_c6c6c6c6.
  - Required: out_state=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid rises exactly 5 cycles after the accept cycle.
- Inverse round-trip:
  - Stimulus: feed 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8 with in_inv=1.
  - Required: out_state=128'hdb135345_f20a225c_d4d4d4d5_2d26314c.
- Parallelism sweep:
  - Stimulus: repeat the first vector with COLS_PER_CYC=2 and COLS_PER_CYC=4.
  - Required: identical out_state; out_valid at T+3 and T+2 respectively.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE, with in_valid=1 and a different in_state throughout.
  - Required: out_state unchanged, in_ready=0, busy=1. After out_ready pulse: in_ready=1 next cycle, and the waiting input is accepted then.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during the 2nd RUN cycle.
  - Required: next cycle out_valid=0, out_state=0, busy=0, in_ready=1. A fresh vector then completes correctly.
- Mode isolation:
  - Stimulus: accept with in_inv=0, then toggle in_inv and in_state during RUN.
  - Required: result equals the forward transform of the originally accepted state.
